// File: rtl/muxn_pkg.sv
// Shared definitions for the muxn_scan channel multiplexer.
//   state_e     : controller states (manual select, auto-scan, frozen scan)
//   Def*        : default parameter values used by muxn_scan and its prescaler
package muxn_pkg;

    typedef enum logic [1:0] {
        StManual = 2'd0,
        StScan   = 2'd1,
        StFrozen = 2'd2
    } state_e;

    localparam int unsigned DefChannels = 4;
    localparam int unsigned DefWidth    = 1;
    localparam int unsigned DefDiv      = 50000000;

endpackage

// File: rtl/muxn_prescaler.sv
// Free-running prescaler for the auto-scan rate.
//   clk_i   : system clock
//   rst_ni  : asynchronous active-low reset
//   clear_i : synchronous clear to 0 (wins over en_i)
//   en_i    : count enable; count holds its value while low
//   tick_o  : combinational, high on the enabled cycle where the count wraps DIV-1 -> 0
module muxn_prescaler
    import muxn_pkg::*;
#(
    parameter int unsigned DIV = DefDiv
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned CntW = $clog2(DIV);
    localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            wrap;

    assign wrap   = (cnt_q == CntLast);
    assign tick_o = en_i && !clear_i && wrap;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = wrap ? '0 : cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/muxn_scan.sv
// N-to-1 channel multiplexer with manual select and timed auto-scan.
//   clk_i     : system clock
//   rst_ni    : asynchronous active-low reset
//   din_i     : packed channel data, channel k at [k*WIDTH +: WIDTH]
//   sel_in_i  : manual channel select (values >= CHANNELS clamp to CHANNELS-1)
//   mode_i    : 0 = manual, 1 = auto-scan
//   hold_i    : freezes auto-scan while high
//   dout_o    : registered data of the selected channel
//   sel_out_o : registered active channel index
//   tick_o    : one-cycle pulse coincident with each auto-scan advance
module muxn_scan
    import muxn_pkg::*;
#(
    parameter int unsigned CHANNELS = DefChannels,
    parameter int unsigned WIDTH    = DefWidth,
    parameter int unsigned DIV      = DefDiv,
    localparam int unsigned SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [CHANNELS*WIDTH-1:0] din_i,
    input  logic [SEL_W-1:0]          sel_in_i,
    input  logic                      mode_i,
    input  logic                      hold_i,
    output logic [WIDTH-1:0]          dout_o,
    output logic [SEL_W-1:0]          sel_out_o,
    output logic                      tick_o
);

    localparam logic [SEL_W-1:0] SelLast = SEL_W'(CHANNELS - 1);

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [WIDTH-1:0]  dout_q, dout_d;
    logic              tick_q;
    logic [SEL_W-1:0]  sel_clamped;
    logic              presc_clear;
    logic              presc_en;
    logic              presc_tick;

    // Manual state and any mode=0 cycle keep the prescaler at 0, so every scan
    // entry from manual starts a full DIV-cycle period.
    assign presc_clear = (state_q == StManual) || !mode_i;
    // A FROZEN cycle with hold released already counts, resuming the period.
    assign presc_en    = mode_i && !hold_i && (state_q != StManual);

    muxn_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (presc_clear),
        .en_i    (presc_en),
        .tick_o  (presc_tick)
    );

    assign sel_clamped = (32'(sel_in_i) >= CHANNELS) ? SelLast : sel_in_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StManual: begin
                if (mode_i) begin
                    state_d = hold_i ? StFrozen : StScan;
                end
            end
            StScan: begin
                if (!mode_i) begin
                    state_d = StManual;
                end else if (hold_i) begin
                    state_d = StFrozen;
                end
            end
            StFrozen: begin
                if (!mode_i) begin
                    state_d = StManual;
                end else if (!hold_i) begin
                    state_d = StScan;
                end
            end
            default: state_d = StManual;
        endcase
    end

    always_comb begin
        sel_d = sel_q;
        if ((state_q == StManual) || !mode_i) begin
            sel_d = sel_clamped;
        end else if (presc_tick) begin
            sel_d = (sel_q == SelLast) ? '0 : sel_q + SEL_W'(1);
        end
    end

    // Mux on the next select so dout and sel_out update on the same edge.
    always_comb begin
        dout_d = '0;
        for (int k = 0; k < int'(CHANNELS); k++) begin
            if (sel_d == SEL_W'(k)) begin
                dout_d = din_i[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StManual;
            sel_q   <= '0;
            dout_q  <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            dout_q  <= dout_d;
            tick_q  <= presc_tick;
        end
    end

    assign dout_o    = dout_q;
    assign sel_out_o = sel_q;
    assign tick_o    = tick_q;

endmodule

// File: tb/tb_muxn_scan.sv
// Bench for muxn_scan: a 4-channel and a 3-channel instance (WIDTH=4, DIV=4)
// share stimulus and are compared every cycle against a behavioural model.
module tb_muxn_scan;

    localparam int Div = 4;
    localparam int MdlManual = 0;
    localparam int MdlScan   = 1;
    localparam int MdlFrozen = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] din;
    logic [1:0]  sel_in;
    logic        mode;
    logic        hold;

    logic [3:0]  dout4, dout3;
    logic [1:0]  selo4, selo3;
    logic        tick4, tick3;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    int m_state[2];
    int m_cnt[2];
    int m_sel[2];
    int m_tick[2];
    int last_tick[2];
    int n_ch[2] = '{4, 3};

    int q_sel4[$];
    int q_dout4[$];
    int q_sel3[$];
    bit record = 1'b0;

    always #5 clk = ~clk;

    muxn_scan #(
        .CHANNELS (4),
        .WIDTH    (4),
        .DIV      (Div)
    ) u_dut4 (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .din_i     (din),
        .sel_in_i  (sel_in),
        .mode_i    (mode),
        .hold_i    (hold),
        .dout_o    (dout4),
        .sel_out_o (selo4),
        .tick_o    (tick4)
    );

    muxn_scan #(
        .CHANNELS (3),
        .WIDTH    (4),
        .DIV      (Div)
    ) u_dut3 (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .din_i     (din[11:0]),
        .sel_in_i  (sel_in),
        .mode_i    (mode),
        .hold_i    (hold),
        .dout_o    (dout3),
        .sel_out_o (selo3),
        .tick_o    (tick3)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic mdl_reset();
        for (int i = 0; i < 2; i++) begin
            m_state[i]   = MdlManual;
            m_cnt[i]     = 0;
            m_sel[i]     = 0;
            m_tick[i]    = 0;
            last_tick[i] = -1000;
        end
    endtask

    // One clock edge of the specified behaviour, using the inputs present at the edge.
    task automatic mdl_step();
        for (int i = 0; i < 2; i++) begin
            int req;
            req = (int'(sel_in) >= n_ch[i]) ? n_ch[i] - 1 : int'(sel_in);
            m_tick[i] = 0;
            if (!mode) begin
                m_state[i] = MdlManual;
                m_cnt[i]   = 0;
                m_sel[i]   = req;
            end else if (m_state[i] == MdlManual) begin
                m_cnt[i]   = 0;
                m_sel[i]   = req;
                m_state[i] = hold ? MdlFrozen : MdlScan;
            end else if (hold) begin
                m_state[i] = MdlFrozen;
            end else begin
                m_state[i] = MdlScan;
                m_cnt[i]++;
                if (m_cnt[i] == Div) begin
                    m_cnt[i]  = 0;
                    m_sel[i]  = (m_sel[i] + 1) % n_ch[i];
                    m_tick[i] = 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        int ed;
        for (int i = 0; i < 2; i++) begin
            logic [3:0] gd;
            logic [1:0] gs;
            logic       gt;
            gd = (i == 0) ? dout4 : dout3;
            gs = (i == 0) ? selo4 : selo3;
            gt = (i == 0) ? tick4 : tick3;
            ed = int'(din[m_sel[i]*4 +: 4]);
            check_eq((i == 0) ? "dout4" : "dout3", 32'(gd), 32'(ed));
            check_eq((i == 0) ? "sel4" : "sel3", 32'(gs), 32'(m_sel[i]));
            check_eq((i == 0) ? "tick4" : "tick3", 32'(gt), 32'(m_tick[i]));
            if (gt === 1'b1) begin
                check_eq("tick_gap", 32'(cyc - last_tick[i] >= Div), 32'd1);
                last_tick[i] = cyc;
            end
        end
        if (record && tick4 === 1'b1) begin
            q_sel4.push_back(int'(selo4));
            q_dout4.push_back(int'(dout4));
        end
        if (record && tick3 === 1'b1) begin
            q_sel3.push_back(int'(selo3));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        cyc++;
        mdl_step();
        #1;
        compare_all();
    endtask

    // Short asynchronous reset pulse between clock edges.
    task automatic reset_pulse();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_dout", 32'({dout4, dout3}), 32'd0);
        check_eq("rst_sel", 32'({selo4, selo3}), 32'd0);
        check_eq("rst_tick", 32'({tick4, tick3}), 32'd0);
        #1;
        rst_n = 1'b1;
        mdl_reset();
    endtask

    initial begin
        int guard;
        int exp_sel[5]  = '{1, 2, 3, 0, 1};
        int exp_dout[5] = '{2, 3, 4, 1, 2};

        rst_n  = 1'b0;
        din    = 16'h0;
        sel_in = 2'd0;
        mode   = 1'b0;
        hold   = 1'b0;
        mdl_reset();
        #1;
        check_eq("reset_dout", 32'({dout4, dout3}), 32'd0);
        check_eq("reset_sel", 32'({selo4, selo3}), 32'd0);
        check_eq("reset_tick", 32'({tick4, tick3}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Manual select of channel 2.
        din    = 16'h4321;
        sel_in = 2'd2;
        cycle();
        check_eq("man_dout", 32'(dout4), 32'h3);
        check_eq("man_sel", 32'(selo4), 32'd2);

        // Out-of-range select clamps on the 3-channel instance.
        sel_in = 2'd3;
        cycle();
        check_eq("clamp_sel3", 32'(selo3), 32'd2);
        check_eq("clamp_dout3", 32'(dout3), 32'h3);

        // Auto-scan from channel 0.
        sel_in = 2'd0;
        cycle();
        mode   = 1'b1;
        record = 1'b1;
        repeat (21) cycle();
        record = 1'b0;
        check_eq("scan_ticks", 32'(q_sel4.size() >= 5), 32'd1);
        for (int k = 0; k < 5; k++) begin
            if (k < q_sel4.size()) begin
                check_eq("scan_sel_seq", 32'(q_sel4[k]), 32'(exp_sel[k]));
                check_eq("scan_dout_seq", 32'(q_dout4[k]), 32'(exp_dout[k]));
            end
        end
        check_eq("wrap3_ticks", 32'(q_sel3.size() >= 3), 32'd1);
        if (q_sel3.size() >= 3) begin
            check_eq("wrap3_sel", 32'(q_sel3[2]), 32'd0);
        end

        // Hold at prescaler count 2, release, expect a tick two cycles later.
        guard = 0;
        while (m_cnt[0] != 2 && guard < 8) begin
            cycle();
            guard++;
        end
        check_eq("reach_cnt2", 32'(m_cnt[0]), 32'd2);
        hold = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cycle();
            check_eq("held_tick", 32'(tick4), 32'd0);
        end
        hold = 1'b0;
        cycle();
        check_eq("release_tick1", 32'(tick4), 32'd0);
        cycle();
        check_eq("release_tick2", 32'(tick4), 32'd1);

        // Freeze, then mode=0 together with hold=1.
        hold = 1'b1;
        cycle();
        mode   = 1'b0;
        sel_in = 2'd1;
        cycle();
        check_eq("frz_to_man_sel", 32'(selo4), 32'd1);
        check_eq("frz_to_man_tick", 32'(tick4), 32'd0);
        cycle();
        check_eq("man_stays_sel", 32'(selo4), 32'd1);

        // Reset pulse mid-scan.
        hold = 1'b0;
        mode = 1'b1;
        repeat (6) cycle();
        reset_pulse();
        sel_in = 2'd3;
        cycle();
        check_eq("post_rst_manual_sel", 32'(selo4), 32'd3);
        repeat (6) cycle();

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            din    = 16'($urandom);
            sel_in = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            if ($urandom_range(0, 9) == 0) hold = ~hold;
            cycle();
            if ($urandom_range(0, 99) == 0) reset_pulse();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
